// File: rtl/ps2_key_event_gen_if.sv
// Byte-stream input and key-event output bundle between the PS/2 byte
// receiver, the key event generator and vga_controller.
interface ps2_key_event_gen_if;
    logic [7:0] ps2_byte;
    logic       ps2_valid;
    logic [7:0] key_in;
    logic       key_en;
    logic       key_ext;
    logic [3:0] key_held;
    logic       proto_err;

    // Byte source side: drives the scan-code stream, observes key events.
    modport master (
        output ps2_byte, ps2_valid,
        input  key_in, key_en, key_ext, key_held, proto_err
    );

    // Event generator side.
    modport slave (
        input  ps2_byte, ps2_valid,
        output key_in, key_en, key_ext, key_held, proto_err
    );
endinterface

// File: rtl/ps2_key_event_gen.sv
// PS/2 set-2 scan-code decoder: strips E0/F0 prefixes, tracks the four arrow
// keys, drops keyboard typematic repeats and generates its own auto-repeat.
module ps2_key_event_gen #(
    parameter int REPEAT_DELAY   = 12500000,
    parameter int REPEAT_PERIOD  = 2500000,
    parameter int PREFIX_TIMEOUT = 250000,
    parameter int CNT_W          = 24
) (
    input logic                iVGA_CLK,
    input logic                iRST_n,
    ps2_key_event_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

    // Held-flag bit for an E0-prefixed code: {up, down, left, right}.
    function automatic logic [3:0] arrow_mask(input logic [7:0] code);
        case (code)
            8'h75:   return 4'b1000;
            8'h72:   return 4'b0100;
            8'h6B:   return 4'b0010;
            8'h74:   return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    // Keyboard status/ack bytes that carry no key information.
    function automatic logic is_status(input logic [7:0] code);
        return (code == 8'hAA) || (code == 8'hFA) || (code == 8'hEE) ||
               (code == 8'hFE) || (code == 8'h00) || (code == 8'hFF);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_active_q, rpt_active_d;
    logic             rpt_first_q, rpt_first_d;
    logic [7:0]       rpt_code_q, rpt_code_d;
    logic [7:0]       key_in_q, key_in_d;
    logic             key_en_q, key_en_d;
    logic             key_ext_q, key_ext_d;
    logic [3:0]       key_held_q, key_held_d;
    logic             proto_err_q, proto_err_d;

    logic       make_req, brk_req, ev_ext, rpt_fire, emit_make;
    logic [7:0] ev_code;
    logic [3:0] ev_mask;

    // Prefix decoding, timeout, held tracking and repeat scheduling.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        to_cnt_d     = (state_q == IDLE) ? '0 : to_cnt_q + 1'b1;
        rpt_cnt_d    = rpt_active_q ? rpt_cnt_q + 1'b1 : '0;
        rpt_active_d = rpt_active_q;
        rpt_first_d  = rpt_first_q;
        rpt_code_d   = rpt_code_q;
        key_in_d     = key_in_q;
        key_en_d     = 1'b0;
        key_ext_d    = key_ext_q;
        key_held_d   = key_held_q;
        proto_err_d  = 1'b0;
        make_req     = 1'b0;
        brk_req      = 1'b0;
        ev_ext       = 1'b0;
        ev_code      = bus.ps2_byte;

        if (bus.ps2_valid) begin
            to_cnt_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (bus.ps2_byte == 8'hE0)         state_d = EXT;
                    else if (bus.ps2_byte == 8'hF0)    state_d = BRK;
                    else if (!is_status(bus.ps2_byte)) make_req = 1'b1;
                end
                EXT: begin
                    if (bus.ps2_byte == 8'hF0) begin
                        state_d = EXT_BRK;
                    end else if (bus.ps2_byte != 8'hE0) begin
                        state_d = IDLE;
                        // 12/59 are the fake-shift codes wrapped around E0 keys.
                        if (bus.ps2_byte != 8'h12 && bus.ps2_byte != 8'h59) begin
                            make_req = 1'b1;
                            ev_ext   = 1'b1;
                        end
                    end
                end
                BRK, EXT_BRK: begin
                    if (bus.ps2_byte == 8'hE0 || bus.ps2_byte == 8'hF0) begin
                        // A prefix after a break prefix is illegal; restart
                        // decoding as if the stray prefix arrived in IDLE.
                        proto_err_d = 1'b1;
                        state_d     = (bus.ps2_byte == 8'hE0) ? EXT : BRK;
                    end else begin
                        brk_req = 1'b1;
                        ev_ext  = (state_q == EXT_BRK);
                        state_d = IDLE;
                    end
                end
            endcase
        end else if (state_q != IDLE && to_cnt_q == TIMEOUT_LAST) begin
            proto_err_d = 1'b1;
            state_d     = IDLE;
            to_cnt_d    = '0;
        end

        ev_mask   = ev_ext ? arrow_mask(ev_code) : 4'b0000;
        rpt_fire  = rpt_active_q &&
                    (rpt_cnt_q == (rpt_first_q ? DELAY_LAST : PERIOD_LAST));
        // An arrow make for an already held arrow is keyboard typematic.
        emit_make = make_req && ((ev_mask & key_held_q) == 4'b0000);

        if (emit_make) begin
            key_en_d  = 1'b1;
            key_in_d  = ev_code;
            key_ext_d = ev_ext;
            if (ev_mask != 4'b0000) begin
                key_held_d   = key_held_q | ev_mask;
                rpt_active_d = 1'b1;
                rpt_first_d  = 1'b1;
                rpt_code_d   = ev_code;
                rpt_cnt_d    = '0;
            end else if (rpt_fire) begin
                // Colliding repeat pulse is dropped; schedule continues.
                rpt_first_d = 1'b0;
                rpt_cnt_d   = '0;
            end
        end else if (brk_req) begin
            key_held_d = key_held_q & ~ev_mask;
            if (ev_mask != 4'b0000 && ev_code == rpt_code_q) begin
                rpt_active_d = 1'b0;
                rpt_cnt_d    = '0;
            end else if (rpt_fire) begin
                rpt_first_d = 1'b0;
                rpt_cnt_d   = '0;
            end
        end else if (rpt_fire) begin
            key_en_d    = 1'b1;
            key_in_d    = rpt_code_q;
            key_ext_d   = 1'b1;
            rpt_first_d = 1'b0;
            rpt_cnt_d   = '0;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q      <= IDLE;
            to_cnt_q     <= '0;
            rpt_cnt_q    <= '0;
            rpt_active_q <= 1'b0;
            rpt_first_q  <= 1'b0;
            rpt_code_q   <= 8'h00;
            key_in_q     <= 8'h00;
            key_en_q     <= 1'b0;
            key_ext_q    <= 1'b0;
            key_held_q   <= 4'b0000;
            proto_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q      <= state_d;
            to_cnt_q     <= to_cnt_d;
            rpt_cnt_q    <= rpt_cnt_d;
            rpt_active_q <= rpt_active_d;
            rpt_first_q  <= rpt_first_d;
            rpt_code_q   <= rpt_code_d;
            key_in_q     <= key_in_d;
            key_en_q     <= key_en_d;
            key_ext_q    <= key_ext_d;
            key_held_q   <= key_held_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign bus.key_in    = key_in_q;
    assign bus.key_en    = key_en_q;
    assign bus.key_ext   = key_ext_q;
    assign bus.key_held  = key_held_q;
    assign bus.proto_err = proto_err_q;
endmodule
